// File: rtl/tpu_pkg.sv
// Shared types for the TPU result checker: row geometry,
// checker state encoding and a lane-slice helper.
package tpu_pkg;

  localparam int MATRIX_SIZE = 8;
  localparam int PSUM_BW     = 20;
  localparam int ROW_W       = MATRIX_SIZE * PSUM_BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } chk_state_e;

  // Lane i of a packed result row.
  function automatic logic [PSUM_BW-1:0] lane(
    input logic [ROW_W-1:0] row,
    input int               i
  );
    return row[i*PSUM_BW +: PSUM_BW];
  endfunction

endpackage

// File: rtl/tpu_result_checker_if.sv
// Result/golden memory read port pair. master = checker side
// (drives strobes/addresses), slave = memory side (returns rows).
interface tpu_result_checker_if #(
  parameter int ADDR_W = 10
);
  import tpu_pkg::*;

  logic              res_rd_en;
  logic              gold_rd_en;
  logic [ADDR_W-1:0] res_addr;
  logic [ADDR_W-1:0] gold_addr;
  logic [ROW_W-1:0]  res_data;
  logic [ROW_W-1:0]  gold_data;

  modport master (
    output res_rd_en, gold_rd_en,
    output res_addr, gold_addr,
    input  res_data, gold_data
  );

  modport slave (
    input  res_rd_en, gold_rd_en,
    input  res_addr, gold_addr,
    output res_data, gold_data
  );

endinterface

// File: rtl/tpu_result_checker_lat_pipe.sv
// RD_LAT-stage valid+address shift register with sync flush.
// Ports: clk, rstn, flush, in_valid/in_addr, out_valid/out_addr, any_valid.
module lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              any_valid
);

  logic [RD_LAT-1:0] v;
  logic [ADDR_W-1:0] a [RD_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++)
        a[i] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= in_valid;
      a[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_addr  = a[RD_LAT-1];
  assign any_valid = |v;

endmodule

// File: rtl/tpu_result_checker.sv
// Result-drain/compare engine: sweeps result+golden rows, compares
// lanes under a mask, reports per-row errors, count, first failure.
// Ports: clk, rstn, trig, abort, base_addr, num_rows, lane_mask,
// mem (read ports), busy, done, cmp_*, err_cnt, first_err_*.
module tpu_result_checker
  import tpu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   trig,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        num_rows,
  input  logic [MATRIX_SIZE-1:0] lane_mask,
  tpu_result_checker_if.master   mem,
  output logic                   busy,
  output logic                   done,
  output logic                   cmp_valid,
  output logic [ADDR_W-1:0]      cmp_addr,
  output logic [MATRIX_SIZE-1:0] cmp_lane_err,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   first_err_valid,
  output logic [ADDR_W-1:0]      first_err_addr
);

  chk_state_e state, state_n;

  logic                   trig_q;
  logic                   start;
  logic [ADDR_W-1:0]      base_q;
  logic [ADDR_W:0]        nrows_q;
  logic [MATRIX_SIZE-1:0] mask_q;
  logic [ADDR_W:0]        idx;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   flush;
  logic                   pv;
  logic [ADDR_W-1:0]      paddr;
  logic                   p_any;
  logic [MATRIX_SIZE-1:0] lerr;

  // Abort is only meaningful mid-sweep; in IDLE it blocks a start.
  assign start   = trig & ~trig_q & ~abort;
  assign rd_en   = (state == ISSUE);
  assign rd_addr = base_q + idx[ADDR_W-1:0];
  assign flush   = abort & (state != IDLE);
  assign busy    = (state != IDLE);

  assign mem.res_rd_en  = rd_en;
  assign mem.gold_rd_en = rd_en;
  assign mem.res_addr   = rd_addr;
  assign mem.gold_addr  = rd_addr;

  lat_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (rd_en),
    .in_addr   (rd_addr),
    .out_valid (pv),
    .out_addr  (paddr),
    .any_valid (p_any)
  );

  always_comb begin
    lerr = '0;
    for (int i = 0; i < MATRIX_SIZE; i++)
      lerr[i] = mask_q[i] &
        (lane(mem.res_data, i) != lane(mem.gold_data, i));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start && num_rows != '0)
          state_n = ISSUE;
      end
      ISSUE: begin
        if (abort)
          state_n = IDLE;
        else if (idx == nrows_q - 1'b1)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (abort || !p_any)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      trig_q          <= 1'b0;
      base_q          <= '0;
      nrows_q         <= '0;
      mask_q          <= '0;
      idx             <= '0;
      done            <= 1'b0;
      cmp_valid       <= 1'b0;
      cmp_addr        <= '0;
      cmp_lane_err    <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      state     <= state_n;
      trig_q    <= trig;
      done      <= 1'b0;
      cmp_valid <= pv & ~abort;

      if (state == IDLE && start) begin
        base_q          <= base_addr;
        nrows_q         <= num_rows;
        mask_q          <= lane_mask;
        idx             <= '0;
        err_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
        done            <= (num_rows == '0);
      end

      if (state == ISSUE)
        idx <= idx + 1'b1;

      if (state == DRAIN && !abort && !p_any)
        done <= 1'b1;

      if (pv) begin
        cmp_addr     <= paddr;
        cmp_lane_err <= lerr;
      end

      if (pv && !abort && (|lerr)) begin
        if (err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= paddr;
        end
      end
    end
  end

endmodule
